// File: rtl/ysyx_22050612_pkg.sv
// Shared definitions for the ysyx_22050612 writeback path: load encodings and
// default widths.
package ysyx_22050612_pkg;

    localparam int WBU_ADDR_W = 5;
    localparam int WBU_DATA_W = 64;
    localparam int WBU_CNT_W  = 2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/ysyx_22050612_wbu_scoreboard.sv
// Per-register pending-write counters: decode increments on issue, the
// writeback output stage decrements; busy flags are read straight off state.
import ysyx_22050612_pkg::*;

module ysyx_22050612_wbu_scoreboard #(
    parameter int ADDR_WIDTH = WBU_ADDR_W,
    parameter int CNT_WIDTH  = WBU_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    output logic                  iss_ready,
    input  logic                  dec_valid,
    input  logic [ADDR_WIDTH-1:0] dec_rd,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  busy1,
    output logic                  busy2
);

    localparam int NREG = 2 ** ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] cnt_q [NREG];
    logic [CNT_WIDTH-1:0] cnt_d [NREG];
    logic                 inc_en;
    logic                 dec_en;

    assign iss_ready = rst_n & ((iss_rd == '0) | (cnt_q[iss_rd] != CNT_MAX));
    assign inc_en    = iss_valid & iss_ready & (iss_rd != '0);
    assign dec_en    = dec_valid & (dec_rd != '0);
    assign busy1     = (cnt_q[rs1] != '0);
    assign busy2     = (cnt_q[rs2] != '0);

    // A decrement on an empty counter is a protocol error; it saturates at 0.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (inc_en && (iss_rd == ADDR_WIDTH'(r)) &&
                !(dec_en && (dec_rd == ADDR_WIDTH'(r)))) begin
                cnt_d[r] = cnt_q[r] + CNT_WIDTH'(1);
            end else if (dec_en && (dec_rd == ADDR_WIDTH'(r)) &&
                         !(inc_en && (iss_rd == ADDR_WIDTH'(r))) &&
                         (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CNT_WIDTH'(1);
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
        end
    end

endmodule

// File: rtl/ysyx_22050612_wbu.sv
// Writeback unit: LSU-priority arbitration, load extension, registered
// register-file write port, and the pending-write scoreboard.
import ysyx_22050612_pkg::*;

module ysyx_22050612_wbu #(
    parameter int ADDR_WIDTH = WBU_ADDR_W,
    parameter int DATA_WIDTH = WBU_DATA_W,
    parameter int CNT_WIDTH  = WBU_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [2:0]            lsu_funct3,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    output logic                  iss_ready,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata
);

    function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [2:0] f3,
                                                       input logic [DATA_WIDTH-1:0] d);
        case (f3)
            F3_LB:   load_ext = {{(DATA_WIDTH-8){d[7]}},   d[7:0]};
            F3_LH:   load_ext = {{(DATA_WIDTH-16){d[15]}}, d[15:0]};
            F3_LW:   load_ext = {{(DATA_WIDTH-32){d[31]}}, d[31:0]};
            F3_LBU:  load_ext = {{(DATA_WIDTH-8){1'b0}},   d[7:0]};
            F3_LHU:  load_ext = {{(DATA_WIDTH-16){1'b0}},  d[15:0]};
            F3_LWU:  load_ext = {{(DATA_WIDTH-32){1'b0}},  d[31:0]};
            default: load_ext = d;
        endcase
    endfunction

    logic                  wen_q,   wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    // LSU wins unconditionally; EXU is held off while a load return is pending.
    assign lsu_ready = rst_n;
    assign exu_ready = rst_n & ~lsu_valid;

    always_comb begin
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (lsu_valid && lsu_ready) begin
            wen_d   = (lsu_rd != '0);
            waddr_d = lsu_rd;
            wdata_d = load_ext(lsu_funct3, lsu_data);
        end else if (exu_valid && exu_ready) begin
            wen_d   = (exu_rd != '0);
            waddr_d = exu_rd;
            wdata_d = exu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign wen   = wen_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

    ysyx_22050612_wbu_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .dec_valid (wen_q),
        .dec_rd    (waddr_q),
        .rs1       (rs1),
        .rs2       (rs2),
        .busy1     (busy1),
        .busy2     (busy2)
    );

endmodule

// File: tb/tb_ysyx_22050612_wbu.sv
// Directed bench for the writeback unit: arbitration, load extension,
// scoreboard counting and asynchronous reset behaviour.
module tb_ysyx_22050612_wbu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exu_valid, exu_ready;
    logic [4:0]  exu_rd;
    logic [63:0] exu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [2:0]  lsu_funct3;
    logic [63:0] lsu_data;
    logic        iss_valid, iss_ready;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1, rs2;
    logic        busy1, busy2;
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ysyx_22050612_wbu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .exu_valid  (exu_valid),
        .exu_ready  (exu_ready),
        .exu_rd     (exu_rd),
        .exu_data   (exu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_funct3 (lsu_funct3),
        .lsu_data   (lsu_data),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .iss_ready  (iss_ready),
        .rs1        (rs1),
        .rs2        (rs2),
        .busy1      (busy1),
        .busy2      (busy2),
        .wen        (wen),
        .waddr      (waddr),
        .wdata      (wdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  ext_f3  [9];
    logic [63:0] ext_in  [9];
    logic [63:0] ext_exp [9];

    initial begin
        ext_f3[0] = 3'b000; ext_in[0] = 64'h80;                  ext_exp[0] = 64'hFFFF_FFFF_FFFF_FF80;
        ext_f3[1] = 3'b100; ext_in[1] = 64'h80;                  ext_exp[1] = 64'h80;
        ext_f3[2] = 3'b010; ext_in[2] = 64'h8000_0000;           ext_exp[2] = 64'hFFFF_FFFF_8000_0000;
        ext_f3[3] = 3'b110; ext_in[3] = 64'h8000_0000;           ext_exp[3] = 64'h8000_0000;
        ext_f3[4] = 3'b001; ext_in[4] = 64'h1234_8001;           ext_exp[4] = 64'hFFFF_FFFF_FFFF_8001;
        ext_f3[5] = 3'b101; ext_in[5] = 64'h1234_8001;           ext_exp[5] = 64'h8001;
        ext_f3[6] = 3'b011; ext_in[6] = 64'hDEAD_BEEF_8000_0000; ext_exp[6] = 64'hDEAD_BEEF_8000_0000;
        ext_f3[7] = 3'b111; ext_in[7] = 64'hCAFE_0000_0000_00FF; ext_exp[7] = 64'hCAFE_0000_0000_00FF;
        ext_f3[8] = 3'b000; ext_in[8] = 64'hFFFF_FF7F;           ext_exp[8] = 64'h7F;

        rst_n = 1'b0;
        exu_valid = 1'b0; exu_rd = '0; exu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_funct3 = '0; lsu_data = '0;
        iss_valid = 1'b0; iss_rd = '0; rs1 = 5'd7; rs2 = 5'd7;

        // Reset state
        tick();
        chk("rst_wen", wen, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_exu_ready", exu_ready, 0);
        chk("rst_lsu_ready", lsu_ready, 0);
        chk("rst_iss_ready", iss_ready, 0);
        chk("rst_busy1", busy1, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rel_exu_ready", exu_ready, 1);
        chk("rel_lsu_ready", lsu_ready, 1);
        chk("rel_iss_ready", iss_ready, 1);

        // EXU-only write to x5
        exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 64'h1234;
        tick();
        exu_valid = 1'b0;
        chk("exu_wen", wen, 1);
        chk("exu_waddr", waddr, 5);
        chk("exu_wdata", wdata, 64'h1234);
        tick();
        chk("exu_wen_drop", wen, 0);
        chk("exu_wdata_hold", wdata, 64'h1234);
        rs1 = 5'd5; #1;
        chk("x5_no_wrap_busy", busy1, 0);
        rs1 = 5'd7;

        // LSU beats EXU in the same cycle
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_funct3 = 3'b011; lsu_data = 64'hAAAA;
        exu_valid = 1'b1; exu_rd = 5'd4; exu_data = 64'h4444;
        #1;
        chk("arb_exu_ready", exu_ready, 0);
        chk("arb_lsu_ready", lsu_ready, 1);
        tick();
        lsu_valid = 1'b0;
        chk("arb_lsu_waddr", waddr, 3);
        chk("arb_lsu_wdata", wdata, 64'hAAAA);
        #1;
        chk("arb_exu_ready2", exu_ready, 1);
        tick();
        exu_valid = 1'b0;
        chk("arb_exu_wen", wen, 1);
        chk("arb_exu_waddr", waddr, 4);
        chk("arb_exu_wdata", wdata, 64'h4444);

        // Back-to-back load returns covering each extension type
        for (int i = 0; i < 9; i++) begin
            lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_funct3 = ext_f3[i]; lsu_data = ext_in[i];
            tick();
            chk($sformatf("ext%0d_wen", i), wen, 1);
            chk($sformatf("ext%0d_wdata", i), wdata, ext_exp[i]);
        end
        lsu_valid = 1'b0;
        tick();
        chk("ext_idle_wen", wen, 0);

        // Scoreboard saturation on x7
        iss_rd = 5'd7; iss_valid = 1'b1;
        #1;
        chk("sb_ready_empty", iss_ready, 1);
        chk("sb_busy_empty", busy1, 0);
        tick();
        chk("sb_busy_m1", busy1, 1);
        tick();
        tick();
        chk("sb_ready_full", iss_ready, 0);
        tick();
        iss_valid = 1'b0;
        chk("sb_ready_full_hold", iss_ready, 0);
        exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 64'h77;
        tick();
        exu_valid = 1'b0;
        chk("sb_wen7", wen, 1);
        chk("sb_ready_before_dec", iss_ready, 0);
        tick();
        chk("sb_ready_after_dec", iss_ready, 1);

        // Issue and write-back of x7 in the same cycle leaves the count at 2
        exu_valid = 1'b1;
        tick();
        exu_valid = 1'b0;
        iss_valid = 1'b1;
        tick();
        iss_valid = 1'b0;
        #1;
        chk("sb_same_cycle", iss_ready, 1);
        iss_valid = 1'b1;
        tick();
        iss_valid = 1'b0;
        chk("sb_after_extra_issue", iss_ready, 0);

        // Drain three writes; busy drops two cycles after the last acceptance
        exu_valid = 1'b1; exu_rd = 5'd7;
        tick();
        tick();
        tick();
        exu_valid = 1'b0;
        chk("drain_busy1_n1", busy1, 1);
        chk("drain_wen_n1", wen, 1);
        tick();
        chk("drain_busy1_n2", busy1, 0);
        chk("drain_busy2_n2", busy2, 0);
        chk("drain_ready_n2", iss_ready, 1);

        // Write to x0 is consumed but never written
        exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 64'hDEAD;
        iss_valid = 1'b1; iss_rd = 5'd0; rs1 = 5'd0;
        #1;
        chk("x0_exu_ready", exu_ready, 1);
        chk("x0_iss_ready", iss_ready, 1);
        tick();
        exu_valid = 1'b0; iss_valid = 1'b0;
        chk("x0_wen", wen, 0);
        chk("x0_busy", busy1, 0);
        rs1 = 5'd7;

        // Asynchronous reset with a write and pending counts in flight
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        tick();
        iss_valid = 1'b0;
        exu_valid = 1'b1; exu_rd = 5'd12; exu_data = 64'h5555;
        tick();
        chk("pre_rst_wen", wen, 1);
        chk("pre_rst_busy1", busy1, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_wen", wen, 0);
        chk("arst_waddr", waddr, 0);
        chk("arst_wdata", wdata, 0);
        chk("arst_busy1", busy1, 0);
        chk("arst_busy2", busy2, 0);
        chk("arst_exu_ready", exu_ready, 0);
        chk("arst_lsu_ready", lsu_ready, 0);
        chk("arst_iss_ready", iss_ready, 0);
        tick();
        chk("arst_hold_wen", wen, 0);
        chk("arst_hold_exu_ready", exu_ready, 0);
        exu_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("post_rst_wen", wen, 0);
        chk("post_rst_busy1", busy1, 0);
        chk("post_rst_exu_ready", exu_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22050612_wbu.md
# ysyx_22050612_wbu

Writeback unit for the ysyx_22050612 core: accepts completed results from the execute unit (EXU) and load returns from the load/store unit (LSU), arbitrates between them, sign/zero-extends load data, and drives the register file write port (wen/waddr/wdata) from registered outputs. It also keeps a per-register pending-write scoreboard that the decode stage queries and updates, so decode never reads a register that still has a write in flight.

## Interface
- ADDR_WIDTH, 5, register index width (32 registers)
- DATA_WIDTH, 64, register data width
- CNT_WIDTH, 2, per-register pending-write counter width (max 3 in flight per rd)

- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- exu_valid  in  1  EXU result valid
- exu_ready  out  1  EXU result accepted this cycle when high with exu_valid
- exu_rd  in  ADDR_WIDTH  destination register
- exu_data  in  DATA_WIDTH  result value
- lsu_valid  in  1  load return valid
- lsu_ready  out  1  load return accepted when high with lsu_valid
- lsu_rd  in  ADDR_WIDTH  destination register
- lsu_funct3  in  3  load type: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu
- lsu_data  in  DATA_WIDTH  raw load data, right-aligned
- iss_valid  in  1  decode issues an instruction writing iss_rd
- iss_rd  in  ADDR_WIDTH  issued destination register
- iss_ready  out  1  low when counter of iss_rd is saturated
- rs1, rs2  in  ADDR_WIDTH  scoreboard query indices
- busy1, busy2  out  1  pending write exists for rs1 / rs2
- wen  out  1  register file write enable
- waddr  out  ADDR_WIDTH  register file write index
- wdata  out  DATA_WIDTH  register file write data

## Operation
- Arbitration: LSU has fixed priority. lsu_ready = rst_n. exu_ready = rst_n & !lsu_valid. At most one result accepted per cycle.
- Load extension: lb/lh/lw sign-extend bit 7/15/31; lbu/lhu/lwu zero-extend; ld passes through; funct3 111 treated as ld.
- Accepted result is registered into wen/waddr/wdata next cycle. If rd==0, the result is consumed (ready handshake completes) but wen stays 0.
- Cycle with no acceptance: wen=0, waddr/wdata hold last value.
- Scoreboard: cnt[r] per register r=1..31; cnt[0] constant 0.
  - Increment on iss_valid & iss_ready & iss_rd!=0.
  - Decrement on wen & waddr!=0 (output stage, not acceptance).
  - Increment and decrement of the same register in one cycle: unchanged.
  - iss_ready = (cnt[iss_rd] != 3); always 1 for iss_rd==0.
  - busy1 = (cnt[rs1]!=0), busy2 = (cnt[rs2]!=0), combinational from counter state.
  - Decrement at cnt==0 is a protocol error; counter stays 0 (no wrap).
- Reset (async, any time, including mid-handshake): wen=0, waddr=0, wdata=0, all counters 0, all ready outputs 0 while rst_n low; in-flight acceptances are dropped.

## Timing
- Acceptance in cycle N -> wen=1 with data in cycle N+1 -> register file updated at end of N+1.
- Counter decrements at end of N+1; busy for that rd drops in N+2, the first cycle the register file read returns the new value.
- Issue in cycle M -> busy visible in M+1.
- Back-to-back acceptances give back-to-back wen pulses, full throughput, no bubbles.
- EXU starved for as long as lsu_valid stays high; no fairness.

## Structure
- Shared package ysyx_22050612_pkg: load funct3 encodings, ADDR_WIDTH/DATA_WIDTH defaults, CNT_WIDTH.
- One sub-module: ysyx_22050612_wbu_scoreboard (counter array, iss_ready, busy1/busy2, decrement input); extension, arbitration, and output register stay in the top.

## Test plan
- EXU only, rd=5, data=0x1234 accepted cycle 3 -> wen=1, waddr=5, wdata=0x1234 in cycle 4; wen=0 in cycle 5.
- LSU and EXU valid in the same cycle (lsu rd=3, exu rd=4) -> exu_ready=0, LSU written first; EXU written on the following acceptance cycle.
- Load extension: lb with data 0x80 -> 0xFFFFFFFFFFFFFF80; lbu with data 0x80 -> 0x80; lw with data 0x80000000 -> 0xFFFFFFFF80000000; lwu with data 0x80000000 -> 0x80000000.
- Scoreboard: issue rd=7 three times -> iss_ready=0 for rd 7; one write to rd 7 -> iss_ready=1; issue and write to rd 7 in the same cycle -> counter unchanged; busy1 with rs1=7 drops exactly 2 cycles after the last acceptance.
- Write to x0, data 0xDEAD -> exu_ready handshake completes, wen stays 0, busy for 0 always 0.
- Assert rst_n low asynchronously while wen=1 and counters nonzero -> wen, waddr, wdata, and all busy outputs go to 0 immediately, without waiting for a clock edge; ready outputs stay 0 until release.
